// File: rtl/nvm_pkg.sv
// Shared NVM definitions: block/page address types, flash opcodes and geometry.
// Used by garbage_collection and gc_page_mover.
`timescale 1ns/1ps
package nvm_pkg;

    localparam int NVM_BLOCK_W = 10;
    localparam int NVM_PAGE_W  = 6;
    localparam int BLOCK_NUM   = 2**NVM_BLOCK_W;
    localparam int PAGE_NUM    = 2**NVM_PAGE_W;

    typedef logic [NVM_BLOCK_W-1:0] block_t;
    typedef logic [NVM_PAGE_W-1:0]  page_t;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_PROG  = 2'b01,
        OP_ERASE = 2'b10
    } flash_op_t;

endpackage

// File: rtl/flash_cmd_issuer.sv
// Single-outstanding flash command issuer.
// Latches a command when requested, holds cmd_* stable through valid/ready,
// then waits for cmd_done and returns a one-cycle done pulse. A cmd_done in
// the acceptance cycle completes the command immediately.
`timescale 1ns/1ps
module flash_cmd_issuer
    import nvm_pkg::*;
#(
    parameter int BLOCK_W = NVM_BLOCK_W,
    parameter int PAGE_W  = NVM_PAGE_W
) (
    input  logic               CLK,
    input  logic               nRST,
    input  logic               req_i,
    input  flash_op_t          op_i,
    input  logic [BLOCK_W-1:0] blk_i,
    input  logic [PAGE_W-1:0]  page_i,
    output logic               done_o,
    output logic               cmd_valid_o,
    input  logic               cmd_ready_i,
    output flash_op_t          cmd_op_o,
    output logic [BLOCK_W-1:0] cmd_blk_o,
    output logic [PAGE_W-1:0]  cmd_page_o,
    input  logic               cmd_done_i
);

    typedef enum logic [1:0] {
        IS_IDLE,
        IS_REQ,
        IS_WAIT
    } issuer_state_t;

    issuer_state_t      st_q, st_d;
    flash_op_t          op_q, op_d;
    logic [BLOCK_W-1:0] blk_q, blk_d;
    logic [PAGE_W-1:0]  page_q, page_d;

    // State and latched command registers
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            st_q   <= IS_IDLE;
            op_q   <= OP_READ;
            blk_q  <= '0;
            page_q <= '0;
        end else begin
            st_q   <= st_d;
            op_q   <= op_d;
            blk_q  <= blk_d;
            page_q <= page_d;
        end
    end

    // Latch on request, hold until accepted, then wait for completion
    always_comb begin
        st_d   = st_q;
        op_d   = op_q;
        blk_d  = blk_q;
        page_d = page_q;
        done_o = 1'b0;
        case (st_q)
            IS_IDLE: begin
                if (req_i) begin
                    op_d   = op_i;
                    blk_d  = blk_i;
                    page_d = page_i;
                    st_d   = IS_REQ;
                end
            end
            IS_REQ: begin
                if (cmd_ready_i) begin
                    if (cmd_done_i) begin
                        done_o = 1'b1;
                        st_d   = IS_IDLE;
                    end else begin
                        st_d   = IS_WAIT;
                    end
                end
            end
            IS_WAIT: begin
                if (cmd_done_i) begin
                    done_o = 1'b1;
                    st_d   = IS_IDLE;
                end
            end
            default: st_d = IS_IDLE;
        endcase
    end

    // Command fields are zero whenever no request is on the bus
    assign cmd_valid_o = (st_q == IS_REQ);
    assign cmd_op_o    = cmd_valid_o ? op_q   : OP_READ;
    assign cmd_blk_o   = cmd_valid_o ? blk_q  : '0;
    assign cmd_page_o  = cmd_valid_o ? page_q : '0;

endmodule

// File: rtl/gc_page_mover.sv
// gc_page_mover: relocates valid pages of a victim block into the active
// block (READ, PROG, remap record per page), then erases the victim and
// returns it as a free block.
// Optional build macro GC_MOVE_STATS_EN adds saturating 32-bit counters
// moved_page_total and erase_total.
`timescale 1ns/1ps
module gc_page_mover
    import nvm_pkg::*;
#(
    parameter int BLOCK_W = NVM_BLOCK_W,
    parameter int PAGE_W  = NVM_PAGE_W
) (
    input  logic               CLK,
    input  logic               nRST,
    input  logic               move_flag,
    input  logic [BLOCK_W-1:0] erase_blk,
    input  logic [BLOCK_W-1:0] active_blk,
    output logic               active_request,
    output logic               vq_en,
    output logic [BLOCK_W-1:0] vq_blk,
    output logic [PAGE_W-1:0]  vq_page,
    input  logic               vq_valid,
    output logic               cmd_valid,
    input  logic               cmd_ready,
    output logic [1:0]         cmd_op,
    output logic [BLOCK_W-1:0] cmd_blk,
    output logic [PAGE_W-1:0]  cmd_page,
    input  logic               cmd_done,
    output logic               remap_valid,
    output logic [BLOCK_W-1:0] remap_src_blk,
    output logic [PAGE_W-1:0]  remap_src_page,
    output logic [BLOCK_W-1:0] remap_dst_blk,
    output logic [PAGE_W-1:0]  remap_dst_page,
    output logic               move_done_flag,
    output logic [BLOCK_W-1:0] free_blk,
    output logic               move_err,
    output logic               busy
`ifdef GC_MOVE_STATS_EN
    ,
    output logic [31:0]        moved_page_total,
    output logic [31:0]        erase_total
`endif
);

    localparam logic [PAGE_W-1:0] PAGE_LAST = PAGE_W'(2**PAGE_W - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_QUERY,
        S_QWAIT,
        S_READ,
        S_PROG,
        S_REMAP,
        S_ALLOC,
        S_NEXT,
        S_ERASE,
        S_DONE
    } mover_state_t;

    mover_state_t       state_q, state_d;
    logic [BLOCK_W-1:0] victim_q, victim_d;
    logic [PAGE_W-1:0]  src_page_q, src_page_d;
    logic [PAGE_W-1:0]  dst_page_q, dst_page_d;

    logic               iss_req;
    flash_op_t          iss_op;
    logic [BLOCK_W-1:0] iss_blk;
    logic [PAGE_W-1:0]  iss_page;
    logic               iss_done;
    flash_op_t          iss_cmd_op;

    // Walk state and page pointers; dst_page survives between moves
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= S_IDLE;
            victim_q   <= '0;
            src_page_q <= '0;
            dst_page_q <= '0;
        end else begin
            state_q    <= state_d;
            victim_q   <= victim_d;
            src_page_q <= src_page_d;
            dst_page_q <= dst_page_d;
        end
    end

    // Next-state logic and per-state output strobes
    always_comb begin
        state_d        = state_q;
        victim_d       = victim_q;
        src_page_d     = src_page_q;
        dst_page_d     = dst_page_q;
        vq_en          = 1'b0;
        vq_blk         = '0;
        vq_page        = '0;
        iss_req        = 1'b0;
        iss_op         = OP_READ;
        iss_blk        = '0;
        iss_page       = '0;
        remap_valid    = 1'b0;
        remap_src_blk  = '0;
        remap_src_page = '0;
        remap_dst_blk  = '0;
        remap_dst_page = '0;
        active_request = 1'b0;
        move_done_flag = 1'b0;
        free_blk       = '0;
        move_err       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (move_flag) begin
                    victim_d   = erase_blk;
                    src_page_d = '0;
                    // Moving a block onto itself would destroy its data
                    if (erase_blk == active_blk) move_err = 1'b1;
                    else                         state_d  = S_QUERY;
                end
            end
            S_QUERY: begin
                vq_en   = 1'b1;
                vq_blk  = victim_q;
                vq_page = src_page_q;
                state_d = S_QWAIT;
            end
            S_QWAIT: begin
                state_d = vq_valid ? S_READ : S_NEXT;
            end
            S_READ: begin
                iss_req  = 1'b1;
                iss_op   = OP_READ;
                iss_blk  = victim_q;
                iss_page = src_page_q;
                if (iss_done) state_d = S_PROG;
            end
            S_PROG: begin
                iss_req  = 1'b1;
                iss_op   = OP_PROG;
                iss_blk  = active_blk;
                iss_page = dst_page_q;
                if (iss_done) state_d = S_REMAP;
            end
            S_REMAP: begin
                remap_valid    = 1'b1;
                remap_src_blk  = victim_q;
                remap_src_page = src_page_q;
                remap_dst_blk  = active_blk;
                remap_dst_page = dst_page_q;
                dst_page_d     = dst_page_q + PAGE_W'(1);
                // Last page of the active block used: ask for a fresh one
                if (dst_page_q == PAGE_LAST) begin
                    active_request = 1'b1;
                    state_d        = S_ALLOC;
                end else begin
                    state_d        = S_NEXT;
                end
            end
            S_ALLOC: begin
                state_d = S_NEXT;
            end
            S_NEXT: begin
                if (src_page_q == PAGE_LAST) begin
                    state_d = S_ERASE;
                end else begin
                    src_page_d = src_page_q + PAGE_W'(1);
                    state_d    = S_QUERY;
                end
            end
            S_ERASE: begin
                iss_req  = 1'b1;
                iss_op   = OP_ERASE;
                iss_blk  = victim_q;
                iss_page = '0;
                if (iss_done) state_d = S_DONE;
            end
            S_DONE: begin
                move_done_flag = 1'b1;
                free_blk       = victim_q;
                state_d        = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    flash_cmd_issuer #(
        .BLOCK_W (BLOCK_W),
        .PAGE_W  (PAGE_W)
    ) u_issuer (
        .CLK         (CLK),
        .nRST        (nRST),
        .req_i       (iss_req),
        .op_i        (iss_op),
        .blk_i       (iss_blk),
        .page_i      (iss_page),
        .done_o      (iss_done),
        .cmd_valid_o (cmd_valid),
        .cmd_ready_i (cmd_ready),
        .cmd_op_o    (iss_cmd_op),
        .cmd_blk_o   (cmd_blk),
        .cmd_page_o  (cmd_page),
        .cmd_done_i  (cmd_done)
    );

    assign cmd_op = iss_cmd_op;
    assign busy   = (state_q != S_IDLE);

`ifdef GC_MOVE_STATS_EN
    logic [31:0] moved_cnt_q;
    logic [31:0] erase_cnt_q;

    // Saturating activity counters
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            moved_cnt_q <= '0;
            erase_cnt_q <= '0;
        end else begin
            if (remap_valid && (moved_cnt_q != 32'hFFFF_FFFF))
                moved_cnt_q <= moved_cnt_q + 32'd1;
            if (move_done_flag && (erase_cnt_q != 32'hFFFF_FFFF))
                erase_cnt_q <= erase_cnt_q + 32'd1;
        end
    end

    assign moved_page_total = moved_cnt_q;
    assign erase_total      = erase_cnt_q;
`endif

endmodule

// File: tb/tb_gc_page_mover.sv
// Directed bench for gc_page_mover: a table of whole-move scenarios with
// hand-computed results, plus a reset-during-READ sequence.
`timescale 1ns/1ps
module tb_gc_page_mover;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        move_flag;
    logic [9:0]  erase_blk;
    logic [9:0]  active_blk;
    logic        active_request;
    logic        vq_en;
    logic [9:0]  vq_blk;
    logic [5:0]  vq_page;
    logic        vq_valid;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [9:0]  cmd_blk;
    logic [5:0]  cmd_page;
    logic        cmd_done;
    logic        remap_valid;
    logic [9:0]  remap_src_blk;
    logic [5:0]  remap_src_page;
    logic [9:0]  remap_dst_blk;
    logic [5:0]  remap_dst_page;
    logic        move_done_flag;
    logic [9:0]  free_blk;
    logic        move_err;
    logic        busy;

    gc_page_mover dut (
        .CLK(CLK), .nRST(nRST), .move_flag(move_flag), .erase_blk(erase_blk),
        .active_blk(active_blk), .active_request(active_request),
        .vq_en(vq_en), .vq_blk(vq_blk), .vq_page(vq_page), .vq_valid(vq_valid),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_blk(cmd_blk), .cmd_page(cmd_page), .cmd_done(cmd_done),
        .remap_valid(remap_valid), .remap_src_blk(remap_src_blk),
        .remap_src_page(remap_src_page), .remap_dst_blk(remap_dst_blk),
        .remap_dst_page(remap_dst_page), .move_done_flag(move_done_flag),
        .free_blk(free_blk), .move_err(move_err), .busy(busy)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // scenario record: remap entries are packed {src_blk, src_page, dst_blk, dst_page}
    typedef struct {
        logic [9:0]  victim, act, nxt;
        logic [63:0] vmap;
        int          rdy, pdly, dly;
        bit          poke;
        int          e_err, e_done, e_rd, e_rm, e_ar, e_q, e_stall, e_cyc, e_idx;
        logic [31:0] e_first, e_chk, e_last;
    } vec_t;

    vec_t tv[7];

    // environment knobs (written by main) and observations (written by responder)
    logic [63:0] vmap = '0;
    int          rdy_dly = 0, pdly = 0, done_dly = 0;
    logic [9:0]  base_active = '0, next_active = '0, cur_victim = '0;
    int          ar_mark = 0;

    int rd_cnt = 0, pg_cnt = 0, er_cnt = 0, ar_cnt = 0, done_cnt = 0, err_cnt = 0;
    int q_cnt = 0, qblk_err = 0, unstable = 0, busy_cyc = 0, done_cyc = 0;
    logic [9:0]  done_blk = '0;
    logic [31:0] rm_q[$];
    logic [17:0] cmd_q[$];
    logic [5:0]  qp_q[$];
    int          stall_q[$];

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] R(input int sb, input int sp, input int db, input int dp);
        return {10'(sb), 6'(sp), 10'(db), 6'(dp)};
    endfunction

    function automatic vec_t mk(input int victim, input int act, input int nxt, input logic [63:0] vm,
                                input int rdy, input int pd, input int dly, input bit poke,
                                input int e_err, input int e_done, input int e_rd, input int e_rm,
                                input int e_ar, input int e_q, input int e_stall, input int e_cyc,
                                input int e_idx, input logic [31:0] f, input logic [31:0] c,
                                input logic [31:0] l);
        vec_t t;
        t.victim = 10'(victim); t.act = 10'(act); t.nxt = 10'(nxt); t.vmap = vm;
        t.rdy = rdy; t.pdly = pd; t.dly = dly; t.poke = poke;
        t.e_err = e_err; t.e_done = e_done; t.e_rd = e_rd; t.e_rm = e_rm; t.e_ar = e_ar;
        t.e_q = e_q; t.e_stall = e_stall; t.e_cyc = e_cyc; t.e_idx = e_idx;
        t.e_first = f; t.e_chk = c; t.e_last = l;
        return t;
    endfunction

    // Flash, valid-store and free-block responder plus output monitor
    initial begin
        logic [17:0] cap;
        bit in_cmd, vq_prev;
        int pend, wcnt, cur_stall, dly;
        in_cmd = 0; vq_prev = 0; pend = 0; wcnt = 0; cur_stall = 0; cap = '0;
        cmd_ready = 0; cmd_done = 0; vq_valid = 0; active_blk = '0;
        forever begin
            @(negedge CLK);
            active_blk = (ar_cnt > ar_mark) ? next_active : base_active;
            cmd_ready = 0;
            cmd_done  = 0;
            if (!nRST) begin
                pend = 0; wcnt = 0; in_cmd = 0; cur_stall = 0; vq_prev = 0; vq_valid = 0;
            end else begin
                if (vq_en) begin
                    vq_valid = vmap[vq_page];
                    q_cnt++;
                    qp_q.push_back(vq_page);
                    if (vq_blk != cur_victim) qblk_err++;
                end else if (!vq_prev) begin
                    vq_valid = 0;
                end
                vq_prev = vq_en;
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) cmd_done = 1;
                end
                if (cmd_valid) begin
                    if (!in_cmd) begin
                        cap = {cmd_op, cmd_blk, cmd_page};
                        in_cmd = 1; wcnt = 0; cur_stall = 0;
                    end else if ({cmd_op, cmd_blk, cmd_page} != cap) begin
                        unstable++;
                    end
                    dly = (cmd_op == 2'b01) ? rdy_dly + pdly : rdy_dly;
                    if (wcnt < dly) begin
                        wcnt++;
                        if (cmd_op == 2'b01) cur_stall++;
                    end else begin
                        cmd_ready = 1;
                        in_cmd = 0;
                        cmd_q.push_back(cap);
                        case (cmd_op)
                            2'b00:   rd_cnt++;
                            2'b01:   begin pg_cnt++; stall_q.push_back(cur_stall); end
                            default: er_cnt++;
                        endcase
                        if (done_dly == 0) cmd_done = 1;
                        else               pend = done_dly;
                    end
                end
                if (remap_valid)
                    rm_q.push_back({remap_src_blk, remap_src_page, remap_dst_blk, remap_dst_page});
                if (active_request) ar_cnt++;
                if (move_done_flag) begin done_cnt++; done_cyc = cyc; done_blk = free_blk; end
                if (move_err) err_cnt++;
                if (busy) busy_cyc++;
            end
        end
    end

    task automatic run_vec(input int v);
        vec_t t;
        int rd0, pg0, er0, ar0, dn0, ee0, q0, qb0, un0, b0, rm0, cq0, st0, t0, smax, srcbad;
        bit got;
        t = tv[v];
        @(posedge CLK); #1;
        vmap = t.vmap; rdy_dly = t.rdy; pdly = t.pdly; done_dly = t.dly;
        base_active = t.act; next_active = t.nxt; ar_mark = ar_cnt; cur_victim = t.victim;
        rd0 = rd_cnt; pg0 = pg_cnt; er0 = er_cnt; ar0 = ar_cnt; dn0 = done_cnt; ee0 = err_cnt;
        q0 = q_cnt; qb0 = qblk_err; un0 = unstable; b0 = busy_cyc;
        rm0 = rm_q.size(); cq0 = cmd_q.size(); st0 = stall_q.size();
        @(posedge CLK); #1;
        erase_blk = t.victim; move_flag = 1; t0 = cyc;
        @(posedge CLK); #1;
        move_flag = 0;
        if (t.poke) begin
            repeat (20) @(posedge CLK);
            #1; erase_blk = t.act; move_flag = 1;
            @(posedge CLK); #1;
            move_flag = 0; erase_blk = t.victim;
        end
        got = 0;
        for (int c = 0; c < 4000; c++) begin
            if (done_cnt != dn0 || err_cnt != ee0) begin got = 1; break; end
            @(posedge CLK); #1;
        end
        chk($sformatf("v%0d_finish_in_budget", v), 64'(got), 64'd1);
        repeat (3) @(posedge CLK);
        #1;
        chk($sformatf("v%0d_move_err", v), 64'(err_cnt - ee0), 64'(t.e_err));
        chk($sformatf("v%0d_move_done", v), 64'(done_cnt - dn0), 64'(t.e_done));
        chk($sformatf("v%0d_reads", v), 64'(rd_cnt - rd0), 64'(t.e_rd));
        chk($sformatf("v%0d_progs", v), 64'(pg_cnt - pg0), 64'(t.e_rd));
        chk($sformatf("v%0d_erases", v), 64'(er_cnt - er0), 64'(t.e_done));
        chk($sformatf("v%0d_remaps", v), 64'(rm_q.size() - rm0), 64'(t.e_rm));
        chk($sformatf("v%0d_active_req", v), 64'(ar_cnt - ar0), 64'(t.e_ar));
        chk($sformatf("v%0d_queries", v), 64'(q_cnt - q0), 64'(t.e_q));
        chk($sformatf("v%0d_qblk", v), 64'(qblk_err - qb0), 64'd0);
        chk($sformatf("v%0d_cmd_stable", v), 64'(unstable - un0), 64'd0);
        chk($sformatf("v%0d_busy_seen", v), 64'(busy_cyc != b0), 64'(t.e_err == 0));
        chk($sformatf("v%0d_busy_end", v), 64'(busy), 64'd0);
        smax = 0;
        for (int i = st0; i < stall_q.size(); i++) if (stall_q[i] > smax) smax = stall_q[i];
        chk($sformatf("v%0d_prog_stall", v), 64'(smax), 64'(t.e_stall));
        if (t.e_q > 0) chk($sformatf("v%0d_first_qpage", v), 64'(qp_q[q0]), 64'd0);
        if (t.e_rm > 0 && rm_q.size() - rm0 == t.e_rm) begin
            chk($sformatf("v%0d_remap_first", v), 64'(rm_q[rm0]), 64'(t.e_first));
            chk($sformatf("v%0d_remap_idx", v), 64'(rm_q[rm0 + t.e_idx]), 64'(t.e_chk));
            chk($sformatf("v%0d_remap_last", v), 64'(rm_q[rm_q.size()-1]), 64'(t.e_last));
            srcbad = 0;
            for (int i = rm0; i < rm_q.size(); i++) if (rm_q[i][31:22] != t.victim) srcbad++;
            chk($sformatf("v%0d_remap_src_blk", v), 64'(srcbad), 64'd0);
        end
        if (t.e_done > 0 && cmd_q.size() > cq0) begin
            chk($sformatf("v%0d_free_blk", v), 64'(done_blk), 64'(t.victim));
            chk($sformatf("v%0d_last_cmd_erase", v), 64'(cmd_q[cmd_q.size()-1]),
                64'({2'b10, t.victim, 6'd0}));
        end
        if (t.e_cyc > 0) chk($sformatf("v%0d_latency", v), 64'(done_cyc - t0), 64'(t.e_cyc));
    endtask

    initial begin
        int c0, rdr;
        bit found;
        tv[0] = mk(5, 9, 9, 64'h8000_0000_0000_0001, 0, 0, 0, 0,
                   0, 1, 2, 2, 0, 64, 0, 0, 1, R(5,0,9,0), R(5,63,9,1), R(5,63,9,1));
        tv[1] = mk(3, 9, 9, 64'h03FF_FFFF_FFFF_FFFF, 1, 0, 2, 0,
                   0, 1, 58, 58, 0, 64, 1, 0, 10, R(3,0,9,2), R(3,10,9,12), R(3,57,9,59));
        tv[2] = mk(4, 9, 12, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 1, 1,
                   0, 1, 64, 64, 1, 64, 0, 0, 4, R(4,0,9,60), R(4,4,12,0), R(4,63,12,59));
        tv[3] = mk(6, 12, 12, 64'h0, 0, 0, 0, 0,
                   0, 1, 0, 0, 0, 64, 0, 195, 0, 32'h0, 32'h0, 32'h0);
        tv[4] = mk(7, 7, 7, 64'h0, 0, 0, 0, 0,
                   1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
        tv[5] = mk(8, 12, 12, 64'h400, 0, 10, 1, 0,
                   0, 1, 1, 1, 0, 64, 10, 0, 0, R(8,10,12,60), R(8,10,12,60), R(8,10,12,60));
        tv[6] = mk(2, 12, 12, 64'h1, 0, 0, 0, 0,
                   0, 1, 1, 1, 0, 64, 0, 0, 0, R(2,0,12,0), R(2,0,12,0), R(2,0,12,0));

        move_flag = 0; erase_blk = '0;
        nRST = 1;
        #1 nRST = 0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_cmd_valid", 64'(cmd_valid), 64'd0);
        chk("rst_vq_en", 64'(vq_en), 64'd0);
        chk("rst_remap_valid", 64'(remap_valid), 64'd0);
        chk("rst_done_err_req", 64'({move_done_flag, move_err, active_request}), 64'd0);
        chk("rst_free_blk", 64'(free_blk), 64'd0);
        nRST = 1;

        for (int v = 0; v < 6; v++) run_vec(v);

        // reset while a READ is being offered
        @(posedge CLK); #1;
        vmap = 64'h1; rdy_dly = 5; pdly = 0; done_dly = 0;
        base_active = 10'd12; ar_mark = ar_cnt; cur_victim = 10'd2;
        @(posedge CLK); #1;
        erase_blk = 10'd2; move_flag = 1;
        @(posedge CLK); #1;
        move_flag = 0;
        found = 0;
        for (int c = 0; c < 50; c++) begin
            if (cmd_valid && cmd_op == 2'b00) begin found = 1; break; end
            @(posedge CLK); #1;
        end
        chk("rstmid_reached_read", 64'(found), 64'd1);
        chk("rstmid_read_blk", 64'(cmd_blk), 64'd2);
        c0 = cmd_q.size(); rdr = rd_cnt;
        nRST = 0;
        #1;
        chk("rstmid_busy", 64'(busy), 64'd0);
        chk("rstmid_cmd_valid", 64'(cmd_valid), 64'd0);
        chk("rstmid_cmd_blk", 64'(cmd_blk), 64'd0);
        chk("rstmid_vq_remap", 64'({vq_en, remap_valid, move_done_flag}), 64'd0);
        repeat (2) @(posedge CLK);
        #1 nRST = 1;
        repeat (10) @(posedge CLK);
        #1;
        chk("rstmid_no_new_cmd", 64'(cmd_q.size() - c0), 64'd0);
        chk("rstmid_no_read_accept", 64'(rd_cnt - rdr), 64'd0);
        chk("rstmid_busy_after", 64'(busy), 64'd0);

        run_vec(6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
